// File: rtl/sram_axi_pkg.sv
// Shared types and AXI3 encodings for the SRAM-like to AXI multi-port bridge.
package sram_axi_pkg;

    localparam int SRAM_AXI_ADDR_W = 32;
    localparam int SRAM_AXI_DATA_W = 32;
    localparam int SRAM_AXI_ID_W   = 4;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [3:0] AXI_LEN_SINGLE   = 4'd0;
    localparam logic [1:0] AXI_LOCK_NORMAL  = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONBUF = 4'b0000;
    localparam logic [2:0] AXI_PROT_DATA    = 3'b000;

    typedef struct packed {
        logic                           wr;
        logic [1:0]                     size;
        logic [SRAM_AXI_DATA_W/8-1:0]   wstrb;
        logic [SRAM_AXI_ADDR_W-1:0]     addr;
        logic [SRAM_AXI_DATA_W-1:0]     wdata;
    } sram_req_t;

    typedef struct packed {
        logic [SRAM_AXI_ID_W-1:0]   id;
        logic [SRAM_AXI_ADDR_W-1:0] addr;
        logic [2:0]                 size;
    } axi_ar_t;

    typedef struct packed {
        logic [SRAM_AXI_ID_W-1:0]   id;
        logic [SRAM_AXI_ADDR_W-1:0] addr;
        logic [2:0]                 size;
    } axi_aw_t;

    // SRAM size code (byte/half/word) maps directly onto AXI AxSIZE.
    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/sram_axi_arb.sv
// Port arbiter: fixed priority (lowest index wins) by default, round-robin when
// SRAM_AXI_RR_ARB_EN is defined.
module sram_axi_arb
#(
    parameter int NUM_PORTS = 2
)
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef SRAM_AXI_RR_ARB_EN
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] nxt_ptr_s;

    // Search from the pointer; the next pointer is one past the winner.
    always_comb begin
        int  idx;
        logic found;
        grant     = {NUM_PORTS{1'b0}};
        nxt_ptr_s = ptr_r;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr_r) + k) % NUM_PORTS;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                nxt_ptr_s  = PTR_W'((idx + 1) % NUM_PORTS);
            end else begin
            end
        end
    end

    // Pointer moves only when the bridge actually accepts the winner.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (advance) begin
            ptr_r <= nxt_ptr_s;
        end
    end
`else
    logic unused_s;
    assign unused_s = clk ^ resetn ^ advance;

    // Lowest-index requester wins.
    always_comb begin
        logic found;
        grant = {NUM_PORTS{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end else begin
            end
        end
    end
`endif

endmodule

// File: rtl/sram_axi_mport_bridge.sv
// Multi-port SRAM-like to AXI3 bridge: tagged reads in flight, single write,
// read/write ordering. Arbitration mode selected by SRAM_AXI_RR_ARB_EN.
module sram_axi_mport_bridge
    import sram_axi_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 4,
    parameter int MAX_RD_OUTST = 4
)
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_PORTS-1:0]          p_req,
    input  logic [NUM_PORTS-1:0]          p_wr,
    input  logic [NUM_PORTS*2-1:0]        p_size,
    input  logic [NUM_PORTS*DATA_W/8-1:0] p_wstrb,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_wdata,
    output logic [NUM_PORTS*DATA_W-1:0]   p_rdata,
    output logic [NUM_PORTS-1:0]          p_addr_ok,
    output logic [NUM_PORTS-1:0]          p_data_ok,
    output logic [ID_W-1:0]               arid,
    output logic [ADDR_W-1:0]             araddr,
    output logic [3:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic [1:0]                    arlock,
    output logic [3:0]                    arcache,
    output logic [2:0]                    arprot,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [ID_W-1:0]               rid,
    input  logic [DATA_W-1:0]             rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    output logic [ID_W-1:0]               awid,
    output logic [ADDR_W-1:0]             awaddr,
    output logic [3:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic [1:0]                    awlock,
    output logic [3:0]                    awcache,
    output logic [2:0]                    awprot,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [ID_W-1:0]               wid,
    output logic [DATA_W-1:0]             wdata,
    output logic [DATA_W/8-1:0]           wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [ID_W-1:0]               bid,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready
);

    localparam int CNT_W = $clog2(MAX_RD_OUTST + 1);
    localparam int STB_W = DATA_W / 8;

    logic [NUM_PORTS-1:0] grant_s;
    logic [NUM_PORTS-1:0] r_done_s;
    sram_req_t            win_req_s;
    logic [ID_W-1:0]      win_id_s;
    logic                 blocked_s;
    logic                 rd_accept_s;
    logic                 wr_accept_s;
    logic                 b_done_s;

    axi_ar_t              ar_r;
    axi_aw_t              aw_r;
    logic [DATA_W-1:0]    wdata_r;
    logic [STB_W-1:0]     wstrb_r;
    logic                 arvalid_r;
    logic                 awvalid_r;
    logic                 wvalid_r;
    logic                 wr_busy_r;
    logic [ID_W-1:0]      wr_port_r;
    logic [CNT_W-1:0]     rd_cnt_r [NUM_PORTS];
    logic [CNT_W-1:0]     rd_total_r;

    logic unused_s;
    assign unused_s = ^{rresp, rlast, bid, bresp};

    sram_axi_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (p_req),
        .advance (rd_accept_s || wr_accept_s),
        .grant   (grant_s)
    );

    // Select the winning port's request fields.
    always_comb begin
        win_req_s = {$bits(sram_req_t){1'b0}};
        win_id_s  = {ID_W{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_s[i]) begin
                win_req_s.wr    = p_wr[i];
                win_req_s.size  = p_size[i*2 +: 2];
                win_req_s.wstrb = p_wstrb[i*STB_W +: STB_W];
                win_req_s.addr  = p_addr[i*ADDR_W +: ADDR_W];
                win_req_s.wdata = p_wdata[i*DATA_W +: DATA_W];
                win_id_s        = ID_W'(i);
            end else begin
            end
        end
    end

    // A blocked winner stalls every port; lower priorities never fall through.
    always_comb begin
        if (win_req_s.wr) begin
            blocked_s = wr_busy_r || arvalid_r || (rd_total_r != {CNT_W{1'b0}});
        end else begin
            blocked_s = arvalid_r || (rd_total_r == CNT_W'(MAX_RD_OUTST)) || wr_busy_r;
        end
        rd_accept_s = (|p_req) && !blocked_s && !win_req_s.wr;
        wr_accept_s = (|p_req) && !blocked_s && win_req_s.wr;
        if (blocked_s) begin
            p_addr_ok = {NUM_PORTS{1'b0}};
        end else begin
            p_addr_ok = grant_s;
        end
    end

    // Response routing; responses with no matching outstanding request are dropped.
    always_comb begin
        r_done_s  = {NUM_PORTS{1'b0}};
        p_data_ok = {NUM_PORTS{1'b0}};
        p_rdata   = {(NUM_PORTS*DATA_W){1'b0}};
        b_done_s  = bvalid && wr_busy_r && !awvalid_r && !wvalid_r;
        for (int i = 0; i < NUM_PORTS; i++) begin
            r_done_s[i]  = rvalid && (rid == ID_W'(i)) && (rd_cnt_r[i] != {CNT_W{1'b0}});
            p_data_ok[i] = r_done_s[i] || (b_done_s && (wr_port_r == ID_W'(i)));
            p_rdata[i*DATA_W +: DATA_W] = rdata;
        end
    end

    // AR holding register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arvalid_r <= 1'b0;
            ar_r      <= {$bits(axi_ar_t){1'b0}};
        end else if (rd_accept_s) begin
            arvalid_r <= 1'b1;
            ar_r.id   <= win_id_s;
            ar_r.addr <= win_req_s.addr;
            ar_r.size <= axi_size(win_req_s.size);
        end else if (arvalid_r && arready) begin
            arvalid_r <= 1'b0;
        end
    end

    // AW/W holding registers; each valid drops on its own handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            wr_busy_r <= 1'b0;
            wr_port_r <= {ID_W{1'b0}};
            aw_r      <= {$bits(axi_aw_t){1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            wstrb_r   <= {STB_W{1'b0}};
        end else if (wr_accept_s) begin
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            wr_busy_r <= 1'b1;
            wr_port_r <= win_id_s;
            aw_r.id   <= win_id_s;
            aw_r.addr <= win_req_s.addr;
            aw_r.size <= axi_size(win_req_s.size);
            wdata_r   <= win_req_s.wdata;
            wstrb_r   <= win_req_s.wstrb;
        end else begin
            if (awvalid_r && awready) begin
                awvalid_r <= 1'b0;
            end
            if (wvalid_r && wready) begin
                wvalid_r <= 1'b0;
            end
            if (b_done_s) begin
                wr_busy_r <= 1'b0;
            end
        end
    end

    // Outstanding read counters; accept and complete in one cycle cancel out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_cnt_r[i] <= {CNT_W{1'b0}};
            end
            rd_total_r <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if ((rd_accept_s && grant_s[i]) && !r_done_s[i]) begin
                    rd_cnt_r[i] <= rd_cnt_r[i] + CNT_W'(1);
                end else if (!(rd_accept_s && grant_s[i]) && r_done_s[i]) begin
                    rd_cnt_r[i] <= rd_cnt_r[i] - CNT_W'(1);
                end
            end
            if (rd_accept_s && !(|r_done_s)) begin
                rd_total_r <= rd_total_r + CNT_W'(1);
            end else if (!rd_accept_s && (|r_done_s)) begin
                rd_total_r <= rd_total_r - CNT_W'(1);
            end
        end
    end

    assign arid    = ar_r.id;
    assign araddr  = ar_r.addr;
    assign arsize  = ar_r.size;
    assign arlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORMAL;
    assign arcache = AXI_CACHE_NONBUF;
    assign arprot  = AXI_PROT_DATA;
    assign arvalid = arvalid_r;
    assign rready  = 1'b1;

    assign awid    = aw_r.id;
    assign awaddr  = aw_r.addr;
    assign awsize  = aw_r.size;
    assign awlen   = AXI_LEN_SINGLE;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = AXI_LOCK_NORMAL;
    assign awcache = AXI_CACHE_NONBUF;
    assign awprot  = AXI_PROT_DATA;
    assign awvalid = awvalid_r;
    assign wid     = aw_r.id;
    assign wdata   = wdata_r;
    assign wstrb   = wstrb_r;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_r;
    assign bready  = 1'b1;

endmodule

// File: tb/tb_sram_axi_mport_bridge.sv
// Self-checking bench for sram_axi_mport_bridge against a transaction-level model.
`timescale 1ns/1ps
module tb_sram_axi_mport_bridge;

    localparam int N    = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = 4;
    localparam int MAXR = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      p_req, p_wr, p_addr_ok, p_data_ok;
    logic [2*N-1:0]    p_size;
    logic [N*DW/8-1:0] p_wstrb;
    logic [N*AW-1:0]   p_addr;
    logic [N*DW-1:0]   p_wdata, p_rdata;
    logic [IW-1:0]     arid, rid, awid, wid, bid;
    logic [AW-1:0]     araddr, awaddr;
    logic [3:0]        arlen, arcache, awlen, awcache;
    logic [2:0]        arsize, arprot, awsize, awprot;
    logic [1:0]        arburst, arlock, rresp, awburst, awlock, bresp;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW-1:0]     rdata, wdata;
    logic [DW/8-1:0]   wstrb;

    sram_axi_mport_bridge #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_RD_OUTST(MAXR)) dut (
        .clk(clk), .resetn(resetn),
        .p_req(p_req), .p_wr(p_wr), .p_size(p_size), .p_wstrb(p_wstrb), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_rdata(p_rdata), .p_addr_ok(p_addr_ok), .p_data_ok(p_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding reads per port, single write, AXI valids.
    int            m_cnt [N];
    bit            m_arv, m_awv, m_wv, m_wbusy;
    int            m_wport;
`ifdef SRAM_AXI_RR_ARB_EN
    int            m_ptr;
`endif
    logic [IW-1:0] m_arid, m_awid;
    logic [AW-1:0] m_araddr, m_awaddr;
    logic [2:0]    m_arsize, m_awsize;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_arv = 1'b0; m_awv = 1'b0; m_wv = 1'b0; m_wbusy = 1'b0; m_wport = 0;
`ifdef SRAM_AXI_RR_ARB_EN
        m_ptr = 0;
`endif
    endtask

    task automatic set_rd(input int p, input logic [31:0] a, input logic [1:0] sz);
        p_req[p] = 1'b1; p_wr[p] = 1'b0;
        p_size[p*2 +: 2] = sz;
        p_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
        p_req[p] = 1'b1; p_wr[p] = 1'b1;
        p_size[p*2 +: 2] = 2'd2;
        p_wstrb[p*4 +: 4] = st;
        p_addr[p*AW +: AW] = a;
        p_wdata[p*DW +: DW] = d;
    endtask

    // One clock: check DUT outputs at the falling edge, then step the model.
    task automatic cycle_check();
        int win, r, p, tot;
        bit acc, blk, wr_win, rd_hit, b_done;
        logic [N-1:0] exp_ok, exp_dok;
        @(negedge clk);
        win = -1;
        for (int k = 0; k < N; k++) begin
`ifdef SRAM_AXI_RR_ARB_EN
            p = (m_ptr + k) % N;
`else
            p = k;
`endif
            if (win < 0 && p_req[p]) win = p;
        end
        tot = 0;
        for (int i = 0; i < N; i++) tot += m_cnt[i];
        acc = 1'b0; wr_win = 1'b0; blk = 1'b0; exp_ok = '0;
        if (win >= 0) begin
            wr_win = p_wr[win];
            if (wr_win) blk = m_wbusy || m_arv || (tot != 0);
            else        blk = m_arv || (tot >= MAXR) || m_wbusy;
            if (!blk) begin acc = 1'b1; exp_ok[win] = 1'b1; end
        end
        exp_dok = '0; rd_hit = 1'b0;
        r = int'(rid);
        if (rvalid && r < N) begin
            if (m_cnt[r] > 0) begin exp_dok[r] = 1'b1; rd_hit = 1'b1; end
        end
        b_done = bvalid && m_wbusy && !m_awv && !m_wv;
        if (b_done) exp_dok[m_wport] = 1'b1;

        chk("addr_ok", 64'(p_addr_ok), 64'(exp_ok));
        chk("data_ok", 64'(p_data_ok), 64'(exp_dok));
        for (int i = 0; i < N; i++)
            if (exp_dok[i] && rd_hit) chk("rdata", 64'(p_rdata[i*DW +: DW]), 64'(rdata));
        chk("arvalid", 64'(arvalid), 64'(m_arv));
        if (m_arv) begin
            chk("arid", 64'(arid), 64'(m_arid));
            chk("araddr", 64'(araddr), 64'(m_araddr));
            chk("arsize", 64'(arsize), 64'(m_arsize));
            chk("arlen_burst", 64'({arlen, arburst}), 64'({4'd0, 2'b01}));
        end
        chk("awvalid", 64'(awvalid), 64'(m_awv));
        chk("wvalid", 64'(wvalid), 64'(m_wv));
        if (m_awv) begin
            chk("awid", 64'(awid), 64'(m_awid));
            chk("awaddr", 64'(awaddr), 64'(m_awaddr));
            chk("awsize", 64'(awsize), 64'(m_awsize));
        end
        if (m_wv) begin
            chk("wdata", 64'(wdata), 64'(m_wdata));
            chk("wstrb_last_id", 64'({wstrb, wlast, wid}), 64'({m_wstrb, 1'b1, m_awid}));
        end

        if (m_arv && arready) m_arv = 1'b0;
        if (m_awv && awready) m_awv = 1'b0;
        if (m_wv && wready) m_wv = 1'b0;
        if (rd_hit) m_cnt[r]--;
        if (b_done) m_wbusy = 1'b0;
        if (acc) begin
            if (wr_win) begin
                m_wbusy = 1'b1; m_awv = 1'b1; m_wv = 1'b1; m_wport = win;
                m_awid = IW'(win);
                m_awaddr = p_addr[win*AW +: AW];
                m_awsize = {1'b0, p_size[win*2 +: 2]};
                m_wdata = p_wdata[win*DW +: DW];
                m_wstrb = p_wstrb[win*4 +: 4];
            end else begin
                m_arv = 1'b1;
                m_arid = IW'(win);
                m_araddr = p_addr[win*AW +: AW];
                m_arsize = {1'b0, p_size[win*2 +: 2]};
                m_cnt[win]++;
            end
`ifdef SRAM_AXI_RR_ARB_EN
            m_ptr = (win + 1) % N;
`endif
        end
        @(posedge clk); #1;
    endtask

    // Return data for every read the model still counts as outstanding.
    task automatic drain();
        int p;
        for (int k = 0; k < 12; k++) begin
            p = -1;
            for (int q = 0; q < N; q++) if (m_cnt[q] > 0 && p < 0) p = q;
            if (p < 0) break;
            rvalid = 1'b1; rid = IW'(p); rdata = $urandom;
            cycle_check();
        end
        rvalid = 1'b0;
    endtask

    initial begin
        int p;
        p_req = '0; p_wr = '0; p_size = '0; p_wstrb = '0; p_addr = '0; p_wdata = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = 2'b00;
        rvalid = 1'b1; rid = '0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1;
        model_reset();

        // Reset state, with a stray response present
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", 64'({arvalid, awvalid, wvalid}), 64'(3'b000));
        chk("rst_readies", 64'({rready, bready}), 64'(2'b11));
        chk("rst_data_ok", 64'(p_data_ok), 64'(2'b00));
        @(posedge clk); #1;
        resetn = 1'b1; rvalid = 1'b0;

        // Port 1 single read, then a write to prove the counters returned to zero
        arready = 1'b1;
        set_rd(1, 32'h1000, 2'd2); cycle_check();
        p_req = '0; cycle_check();
        rvalid = 1'b1; rid = 4'd1; rdata = 32'hDEADBEEF; cycle_check();
        rvalid = 1'b0;
        awready = 1'b1; wready = 1'b1;
        set_wr(0, 32'h3000, 4'hF, $urandom); cycle_check();
        p_req = '0; cycle_check();
        bvalid = 1'b1; cycle_check();
        bvalid = 1'b0; cycle_check();

        // Both ports contend; port 0 keeps re-requesting
        set_rd(1, $urandom & 32'hFFFF_FFFC, 2'd2);
        for (int k = 0; k < 4; k++) begin
            set_rd(0, $urandom & 32'hFFFF_FFFC, 2'd2);
            cycle_check();
        end
        p_req = '0; cycle_check();
        drain();

        // Fill all read slots, then free one
        for (int k = 0; k < 10; k++) begin
            p_req = '0;
            set_rd(int'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 2)));
            cycle_check();
        end
        p = (m_cnt[0] > 0) ? 0 : 1;
        rvalid = 1'b1; rid = IW'(p); rdata = $urandom; cycle_check();
        rvalid = 1'b0; cycle_check();
        p_req = '0; cycle_check();
        drain();

        // Write waits for an outstanding read; awready lags wready by 3 cycles
        set_rd(1, $urandom, 2'd1); cycle_check();
        p_req = '0; cycle_check();
        awready = 1'b0; wready = 1'b0;
        set_wr(0, 32'h2000, 4'hF, $urandom); cycle_check(); cycle_check();
        rvalid = 1'b1; rid = 4'd1; rdata = $urandom; cycle_check();
        rvalid = 1'b0; cycle_check();
        p_req = '0; wready = 1'b1; cycle_check();
        wready = 1'b0; cycle_check(); cycle_check();
        awready = 1'b1; cycle_check();
        awready = 1'b0;
        bvalid = 1'b1; cycle_check(); cycle_check();
        bvalid = 1'b0; cycle_check();

        // Read stalls behind a busy write
        awready = 1'b1; wready = 1'b1;
        set_wr(1, $urandom, 4'($urandom), $urandom); cycle_check();
        p_req = '0; set_rd(0, $urandom, 2'd0); cycle_check(); cycle_check(); cycle_check();
        bvalid = 1'b1; cycle_check();
        bvalid = 1'b0; cycle_check();
        p_req = '0; cycle_check();
        drain();

        // Random traffic, including stray and out-of-range responses
        for (int k = 0; k < 120; k++) begin
            p_req = 2'($urandom);
            for (int q = 0; q < N; q++) begin
                if ($urandom_range(0, 3) == 0) set_wr(q, $urandom, 4'($urandom), $urandom);
                else set_rd(q, $urandom, 2'($urandom_range(0, 2)));
                p_req[q] = p_req[q] & ($urandom_range(0, 1) == 1);
            end
            arready = 1'($urandom); awready = 1'($urandom); wready = 1'($urandom);
            bvalid = ($urandom_range(0, 3) == 0);
            rvalid = 1'($urandom);
            rdata = $urandom;
            p = -1;
            for (int q = 0; q < N; q++) if (m_cnt[q] > 0 && p < 0) p = q;
            if (p >= 0 && $urandom_range(0, 3) != 0) rid = IW'(p);
            else rid = IW'($urandom_range(0, 5));
            cycle_check();
        end
        p_req = '0; rvalid = 1'b0; bvalid = 1'b0;
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        cycle_check(); cycle_check();
        bvalid = 1'b1; cycle_check();
        bvalid = 1'b0;
        drain();

        // Reset with two reads in flight; late responses must be dropped
        set_rd(0, $urandom, 2'd2); cycle_check();
        p_req = '0; cycle_check();
        set_rd(1, $urandom, 2'd2); cycle_check();
        p_req = '0;
        resetn = 1'b0; rvalid = 1'b1; rid = 4'd0;
        @(negedge clk);
        chk("mid_rst_valids", 64'({arvalid, awvalid, wvalid}), 64'(3'b000));
        chk("mid_rst_data_ok", 64'(p_data_ok), 64'(2'b00));
        @(posedge clk); #1;
        resetn = 1'b1; model_reset();
        rvalid = 1'b1; rid = 4'd0; rdata = $urandom; cycle_check();
        rid = 4'd1; cycle_check();
        rvalid = 1'b0; cycle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
